// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified memory port of the multicycle MIPS between the
// instruction-fetch path and the load/store path. One requester is served at
// a time. The arbiter waits out the memory read latency and performs byte and
// halfword accesses. Loads (lbu/lhu/lw) are lane-extracted and zero-extended.
// Subword stores (sb/sh) are done as read-modify-write.
//
// Optional feature macro: MEM_ARB_RR_EN
//   undefined : fixed priority on conflict, data wins over fetch
//   defined   : round-robin on conflict, driven by a 1-bit last-grant flag
//
// Parameters
//   MEM_LAT    memory read latency in cycles (1..15)
//
// Ports
//   Clk        clock, every state update happens on the rising edge
//   Reset      synchronous, active-high
//   if_req     fetch request, held until if_ack
//   if_addr    fetch address (bits [1:0] ignored)
//   if_ack     one-cycle pulse, if_rdata valid
//   if_rdata   fetched word
//   d_req      data request, held until d_ack
//   d_wr       1 = store, 0 = load
//   d_size     00 byte, 01 halfword, 10 word, 11 illegal
//   d_addr     byte address
//   d_wdata    store data, right-aligned for byte/halfword
//   d_ack      one-cycle pulse, data transaction finished
//   d_rdata    load data, lane-extracted and zero-extended
//   d_err      pulses with d_ack on a misaligned or illegal request
//   mem_addr   word address to memory
//   mem_wr     memory write strobe, one cycle per write
//   mem_wdata  write word
//   mem_rdata  memory read data
//   busy       high in every state except IDLE
//   state_out  current state encoding (debug)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_MERGE = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // The read word is sampled in the last RD cycle, MEM_LAT edges after
    // mem_addr was registered.
    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;

    // Transaction context, captured when the request is granted.
    logic        owner_d;      // 1 = data path owns the port, 0 = fetch
    logic        lat_wr;
    logic [1:0]  lat_size;
    logic [1:0]  lat_off;
    logic [15:0] lat_wdata;
    logic [31:0] rd_word;      // old memory word for read-modify-write

    logic        grant_any;
    logic        grant_d;
    logic        d_illegal;
    logic        rd_done;
    logic [31:0] sel_addr;

`ifdef MEM_ARB_RR_EN
    logic        last_grant;   // 1 = data was granted most recently
`endif

    // Size 11 is never legal. Halfwords must be 2-byte aligned and words
    // must be 4-byte aligned.
    function automatic logic size_illegal(input logic [1:0] size,
                                          input logic [1:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    // Pick the addressed little-endian lane(s) and zero-extend them.
    function automatic logic [31:0] lane_extract(input logic [31:0] w,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off);
        case (size)
            2'b00:   return {24'd0, w[{off, 3'b000} +: 8]};
            2'b01:   return {16'd0, w[{off[1], 4'b0000} +: 16]};
            default: return w;
        endcase
    endfunction

    // Overwrite the addressed lane(s) of the old word with the store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] w,
                                               input logic [15:0] d,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] r;
        r = w;
        case (size)
            2'b00:   r[{off, 3'b000} +: 8]     = d[7:0];
            2'b01:   r[{off[1], 4'b0000} +: 16] = d;
            default: r = w;
        endcase
        return r;
    endfunction

    assign busy      = (state != ST_IDLE);
    assign state_out = state;

    always_comb begin
        state_nxt = state;
        grant_any = if_req | d_req;
`ifdef MEM_ARB_RR_EN
        // On a conflict, grant whichever side was not served last.
        grant_d   = d_req & (~if_req | ~last_grant);
`else
        grant_d   = d_req;
`endif
        sel_addr  = grant_d ? d_addr : if_addr;
        d_illegal = size_illegal(d_size, d_addr[1:0]);
        rd_done   = (cnt == LAST_CNT);

        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    if (!grant_d) begin
                        state_nxt = ST_RD;
                    end else if (d_illegal) begin
                        state_nxt = ST_DONE;
                    end else if (d_wr && d_size == 2'b10) begin
                        state_nxt = ST_WR;
                    end else begin
                        state_nxt = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (rd_done) begin
                    state_nxt = lat_wr ? ST_MERGE : ST_DONE;
                end
            end
            ST_MERGE: state_nxt = ST_WR;
            ST_WR:    state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            mem_wr    <= 1'b0;
            if_rdata  <= 32'd0;
            d_rdata   <= 32'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
`ifdef MEM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state  <= state_nxt;
            // The strobes are single-cycle. Each one is set only on the edge
            // that enters the state it belongs to.
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            d_err  <= 1'b0;
            mem_wr <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        owner_d   <= grant_d;
                        lat_wr    <= grant_d & d_wr;
                        lat_size  <= grant_d ? d_size : 2'b10;
                        lat_off   <= sel_addr[1:0];
                        lat_wdata <= d_wdata[15:0];
                        cnt       <= 4'd0;
`ifdef MEM_ARB_RR_EN
                        last_grant <= grant_d;
`endif
                        // An illegal request never touches the memory port.
                        if (state_nxt != ST_DONE) begin
                            mem_addr <= {sel_addr[31:2], 2'b00};
                        end
                        if (state_nxt == ST_WR) begin
                            mem_wdata <= d_wdata;
                            mem_wr    <= 1'b1;
                        end
                        if (state_nxt == ST_DONE) begin
                            d_ack <= 1'b1;
                            d_err <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    cnt <= cnt + 4'd1;
                    if (rd_done) begin
                        if (!owner_d) begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end else if (lat_wr) begin
                            rd_word <= mem_rdata;
                        end else begin
                            d_rdata <= lane_extract(mem_rdata, lat_size, lat_off);
                            d_ack   <= 1'b1;
                        end
                    end
                end
                ST_MERGE: begin
                    mem_wdata <= lane_merge(rd_word, lat_wdata, lat_size, lat_off);
                    mem_wr    <= 1'b1;
                end
                ST_WR: begin
                    // Only the data path ever writes.
                    d_ack <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A behavioural memory with a
// MEM_LAT=2 read pipeline drives the DUT. A reference copy of the memory,
// together with plain arithmetic rules, predicts every latency, read value,
// write and arbitration order. Compile with MEM_ARB_RR_EN defined to check
// the round-robin build.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [2:0]  state_out;

    mem_port_arbiter #(.MEM_LAT(LAT)) dut (
        .Clk(Clk), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .state_out(state_out)
    );

    always #5 Clk = ~Clk;

    // Memory: 64 words decoded from address bits [7:2]. Read data appears
    // two edges after the address (one register stage after the edge that
    // registers mem_addr).
    logic [31:0] mem [0:63];
    logic [31:0] rd_q;
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'd0;

    always @(posedge Clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
        rd_q <= mem[mem_addr[7:2]];
    end
    assign mem_rdata = rd_q;

    // Event counters sampled on each edge.
    int          wr_cnt = 0;
    int          rd_cyc = 0;
    int          dack_cnt = 0;
    logic [31:0] last_wa = 32'd0;
    logic [31:0] last_wd = 32'd0;

    always @(posedge Clk) begin
        if (mem_wr) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end
        if (state_out == 3'd1) rd_cyc <= rd_cyc + 1;
        if (d_ack) dack_cnt <= dack_cnt + 1;
    end

    // Reference state.
    logic [31:0] ref_mem [0:63];
    bit          ref_last = 1'b1;   // 1 = data granted most recently
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic bit illegal_f(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'd3) return 1'b1;
        if (s == 2'd1) return a[0];
        if (s == 2'd2) return a[1:0] != 2'd0;
        return 1'b0;
    endfunction

    function automatic int shift_f(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'd0) return 8 * int'(a[1:0]);
        if (s == 2'd1) return 16 * int'(a[1]);
        return 0;
    endfunction

    function automatic logic [31:0] mask_f(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'd0) return 32'h0000_00FF << shift_f(s, a);
        if (s == 2'd1) return 32'h0000_FFFF << shift_f(s, a);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic do_data(input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        bit          ill;
        bit          got;
        int          n;
        int          lat_exp;
        int          wr0;
        int          rd0;
        logic [31:0] w;
        logic [31:0] m;
        logic [31:0] nw;
        ill     = illegal_f(sz, a);
        lat_exp = ill ? 1 : (!wr ? LAT + 1 : (sz == 2'd2 ? 2 : LAT + 3));
        w       = ref_mem[a[7:2]];
        m       = mask_f(sz, a);
        wr0     = wr_cnt;
        rd0     = rd_cyc;
        d_req = 1'b1; d_wr = wr; d_size = sz; d_addr = a; d_wdata = wd;
        got = 1'b0;
        n = 0;
        while (!got && n < 64) begin
            tick();
            n++;
            if (d_ack) got = 1'b1;
        end
        d_req = 1'b0;
        chk("d_latency", 32'(n), 32'(lat_exp));
        chk("d_err", 32'(d_err), 32'(ill));
        chk("d_state_at_ack", 32'(state_out), 32'd4);
        chk("d_busy_at_ack", 32'(busy), 32'd1);
        if (!wr && !ill) chk("d_rdata", d_rdata, (w & m) >> shift_f(sz, a));
        chk("d_write_count", 32'(wr_cnt - wr0), (wr && !ill) ? 32'd1 : 32'd0);
        chk("d_rd_cycles", 32'(rd_cyc - rd0), (ill || (wr && sz == 2'd2)) ? 32'd0 : 32'(LAT));
        if (wr && !ill) begin
            nw = (w & ~m) | ((wd << shift_f(sz, a)) & m);
            chk("d_write_addr", last_wa, {a[31:2], 2'b00});
            chk("d_write_data", last_wd, nw);
            ref_mem[a[7:2]] = nw;
        end
        ref_last = 1'b1;
        tick();
        chk("d_idle_after", 32'({busy, d_ack}), 32'd0);
    endtask

    task automatic do_fetch(input logic [31:0] a);
        bit got;
        int n;
        int wr0;
        wr0 = wr_cnt;
        if_req = 1'b1; if_addr = a;
        got = 1'b0;
        n = 0;
        while (!got && n < 64) begin
            tick();
            n++;
            if (if_ack) got = 1'b1;
        end
        if_req = 1'b0;
        chk("if_latency", 32'(n), 32'(LAT + 1));
        chk("if_rdata", if_rdata, ref_mem[a[7:2]]);
        chk("if_no_write", 32'(wr_cnt - wr0), 32'd0);
        ref_last = 1'b0;
        tick();
        chk("if_idle_after", 32'({busy, if_ack}), 32'd0);
    endtask

    // Both sides request together. Whichever side is served first re-requests
    // once more (with a new address) while the other side is still pending.
    task automatic do_conflict();
        bit          exp_k [3];
        bit          obs_k [3];
        int          obs_t [3];
        int          rem_d;
        int          rem_f;
        int          nk;
        int          n;
        bit          lst;
        bit          first_done;
        logic [31:0] da;
        logic [31:0] fa;
        lst   = ref_last;
        rem_d = 1;
        rem_f = 1;
        for (int i = 0; i < 3; i++) begin
            bit g;
            if (rem_d > 0 && rem_f > 0) begin
`ifdef MEM_ARB_RR_EN
                g = ~lst;
`else
                g = 1'b1;
`endif
                if (i == 0) begin
                    if (g) rem_d = 2;
                    else rem_f = 2;
                end
            end else begin
                g = (rem_d > 0);
            end
            if (g) rem_d--;
            else rem_f--;
            lst = g;
            exp_k[i] = g;
        end
        ref_last = lst;

        for (int i = 0; i < 3; i++) begin
            obs_k[i] = 1'b0;
            obs_t[i] = -1;
        end
        da = $urandom & 32'hFFFF_FFFC;
        fa = $urandom;
        d_wr = 1'b0; d_size = 2'b10; d_addr = da; if_addr = fa;
        d_req = 1'b1; if_req = 1'b1;
        rem_d = 1; rem_f = 1; first_done = 1'b0; nk = 0; n = 0;
        while (nk < 3 && n < 200) begin
            tick();
            n++;
            if (d_ack) begin
                chk("conf_d_rdata", d_rdata, ref_mem[da[7:2]]);
                if (nk < 3) begin obs_k[nk] = 1'b1; obs_t[nk] = n; end
                nk++;
                if (!first_done) begin first_done = 1'b1; rem_d++; end
                rem_d--;
                if (rem_d > 0) begin
                    da = $urandom & 32'hFFFF_FFFC;
                    d_addr = da;
                end else begin
                    d_req = 1'b0;
                end
            end
            if (if_ack) begin
                chk("conf_if_rdata", if_rdata, ref_mem[fa[7:2]]);
                if (nk < 3) begin obs_k[nk] = 1'b0; obs_t[nk] = n; end
                nk++;
                if (!first_done) begin first_done = 1'b1; rem_f++; end
                rem_f--;
                if (rem_f > 0) begin
                    fa = $urandom;
                    if_addr = fa;
                end else begin
                    if_req = 1'b0;
                end
            end
        end
        d_req = 1'b0;
        if_req = 1'b0;
        chk("conf_ack_count", 32'(nk), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("conf_grant_order", 32'(obs_k[i]), 32'(exp_k[i]));
            chk("conf_ack_time", 32'(obs_t[i]), 32'((LAT + 1) + i * (LAT + 2)));
        end
        tick();
    endtask

    task automatic do_b2b_fetch(input logic [31:0] a1, input logic [31:0] a2);
        int n;
        int c1;
        int c2;
        c1 = -1;
        c2 = -1;
        n = 0;
        if_req = 1'b1; if_addr = a1;
        while (c2 < 0 && n < 100) begin
            tick();
            n++;
            if (if_ack) begin
                if (c1 < 0) begin
                    c1 = n;
                    chk("b2b_rdata1", if_rdata, ref_mem[a1[7:2]]);
                    if_addr = a2;
                end else begin
                    c2 = n;
                    chk("b2b_rdata2", if_rdata, ref_mem[a2[7:2]]);
                    if_req = 1'b0;
                end
            end
        end
        if_req = 1'b0;
        chk("b2b_first_latency", 32'(c1), 32'(LAT + 1));
        chk("b2b_spacing", 32'(c2 - c1), 32'(LAT + 2));
        ref_last = 1'b0;
        tick();
    endtask

    task automatic do_reset_mid_sb(input logic [31:0] a, input logic [31:0] wd);
        int          n;
        int          ack0;
        logic [31:0] w;
        logic [31:0] m;
        w = ref_mem[a[7:2]];
        m = mask_f(2'd0, a);
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'b00; d_addr = a; d_wdata = wd;
        n = 0;
        tick();
        while (state_out != 3'd3 && n < 64) begin
            tick();
            n++;
        end
        chk("rst_reached_wr", 32'(state_out), 32'd3);
        chk("rst_wr_strobe", 32'(mem_wr), 32'd1);
        ack0 = dack_cnt;
        // The strobe is already high in this cycle, so memory commits the
        // write on the reset edge.
        ref_mem[a[7:2]] = (w & ~m) | ((wd << shift_f(2'd0, a)) & m);
        Reset = 1'b1;
        d_req = 1'b0;
        tick();
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        Reset = 1'b0;
        ref_last = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_no_late_ack", 32'(dack_cnt - ack0), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  s;
        logic        w;

        // Preload memory while reset is held.
        pl_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pl_idx = 6'(i);
            pl_val = (i < 2) ? 32'h1122_3344 : $urandom;
            ref_mem[i] = pl_val;
            tick();
        end
        pl_en = 1'b0;
        tick();

        chk("reset_acks", 32'({if_ack, d_ack, d_err}), 32'd0);
        chk("reset_mem_wr", 32'(mem_wr), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_if_rdata", if_rdata, 32'd0);
        chk("reset_d_rdata", d_rdata, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        Reset = 1'b0;
        tick();

        // First conflict after reset.
        do_conflict();

        // lbu from 0x102 over 0x11223344.
        do_data(1'b0, 2'b00, 32'h0000_0102, 32'd0);
        chk("lbu_0x102", d_rdata, 32'h0000_0022);
        // sh to 0x106 over 0x11223344.
        do_data(1'b1, 2'b01, 32'h0000_0106, 32'h5555_ABCD);
        chk("sh_waddr", last_wa, 32'h0000_0104);
        chk("sh_wdata", last_wd, 32'hABCD_3344);

        // Misaligned word load and halfword store.
        do_data(1'b0, 2'b10, 32'h0000_0101, 32'd0);
        do_data(1'b1, 2'b01, 32'h0000_0103, 32'h0000_1234);
        // Illegal size, and a word store.
        do_data(1'b0, 2'b11, 32'h0000_0040, 32'd0);
        do_data(1'b1, 2'b10, 32'h0000_0048, 32'hDEAD_BEEF);

        // Repeated conflict, then back-to-back fetches.
        do_conflict();
        do_b2b_fetch($urandom, $urandom);

        // Reset in the WR state of an sb, then a normal access to the same word.
        a = $urandom;
        do_reset_mid_sb(a, $urandom);
        do_data(1'b0, 2'b10, {a[31:2], 2'b00}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: do_fetch($urandom);
                1: do_conflict();
                default: begin
                    a = $urandom;
                    s = 2'($urandom_range(0, 3));
                    w = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) != 0) begin
                        if (s == 2'd1) a[0] = 1'b0;
                        if (s == 2'd2) a[1:0] = 2'b00;
                    end
                    do_data(w, s, a, $urandom);
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
